// File: rtl/led_mode_mux.sv
// rtl/led_mode_mux.sv - debounced mode-key cycling mux from LED pattern drivers onto the LED pins
// Blanking on mode change is built only when LED_MUX_BLANK_EN is defined.
module led_mode_mux #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BLANK_CYCLES    = 256,
    parameter int MODE_W          = $clog2(NUM_MODES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_in,
    input  logic [NUM_MODES*8-1:0] mode_led_in,
    output logic [7:0]             led_out,
    output logic [MODE_W-1:0]      mode,
    output logic                   mode_changed,
    output logic                   busy
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    if (NUM_MODES < 2 || NUM_MODES > 8) begin : g_bad_num_modes
        $error("led_mode_mux: NUM_MODES must be 2..8");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("led_mode_mux: DEBOUNCE_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("led_mode_mux: BLANK_CYCLES must be at least 1");
    end

    logic              key_s1;
    logic              key_s2;
    logic              key_stable;
    logic [DCNT_W-1:0] dcnt;
    logic              rise;
    logic [7:0]        sel_led;
    logic [MODE_W-1:0] mode_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
        end
    end

    // Any cycle where the synchronized key agrees with the stable value restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_stable <= 1'b0;
            dcnt       <= '0;
        end else if (key_s2 == key_stable) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            key_stable <= key_s2;
            dcnt       <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Press is the edge on which key_stable flips 0->1, so mode moves on that same edge.
    assign rise = key_s2 && !key_stable && (dcnt == DCNT_LAST);

    always_comb begin
        sel_led = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode == MODE_W'(i)) begin
                sel_led = mode_led_in[i*8 +: 8];
            end
        end
    end

    assign mode_adv = (mode == LAST_MODE) ? '0 : mode + MODE_W'(1);

`ifdef LED_MUX_BLANK_EN
    localparam int BCNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        RUN,
        BLANK
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_nx;
    logic [7:0]        led_nx;
    logic [MODE_W-1:0] mode_nx;
    logic              mc_nx;
    logic              busy_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            bcnt         <= '0;
            led_out      <= '0;
            mode         <= '0;
            mode_changed <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            bcnt         <= bcnt_nx;
            led_out      <= led_nx;
            mode         <= mode_nx;
            mode_changed <= mc_nx;
            busy         <= busy_nx;
        end
    end

    // Presses landing in BLANK are dropped; only the debouncer sees them.
    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        led_nx   = sel_led;
        mode_nx  = mode;
        mc_nx    = 1'b0;
        busy_nx  = 1'b0;
        case (state)
            RUN: begin
                if (rise) begin
                    state_nx = BLANK;
                    bcnt_nx  = '0;
                    led_nx   = '0;
                    mode_nx  = mode_adv;
                    mc_nx    = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            BLANK: begin
                led_nx  = '0;
                busy_nx = 1'b1;
                if (bcnt == BCNT_LAST) begin
                    state_nx = RUN;
                    bcnt_nx  = '0;
                    busy_nx  = 1'b0;
                end else begin
                    bcnt_nx = bcnt + 1'b1;
                end
            end
            default: begin
                state_nx = RUN;
                bcnt_nx  = '0;
            end
        endcase
    end
`else
    // Without blanking the old pattern is still driven on the press edge, the new one from the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out      <= '0;
            mode         <= '0;
            mode_changed <= 1'b0;
        end else begin
            led_out      <= sel_led;
            mode_changed <= rise;
            if (rise) begin
                mode <= mode_adv;
            end
        end
    end

    assign busy = 1'b0;
`endif

endmodule
